// File: rtl/uart_pkg.sv
// Shared types and character constants for the UART line buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_BS = 8'h08;

endpackage

// File: rtl/line_buf_ram.sv
// Line storage: one write port, one registered read port, no reset.
module line_buf_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_line_buffer.sv
// Collects a line of received characters (with backspace editing) and, on CR,
// replays it to the transmitter followed by CR LF.
//   state   | meaning
//   COLLECT | accept rx characters into the line buffer
//   DRAIN   | send stored characters in order
//   SEND_CR | send carriage return
//   SEND_LF | send line feed, then clear the line
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_valid,
  output logic [DATA_WIDTH-1:0]      tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] line_len,
  output logic                       busy,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic            ovf_q, ovf_d;
  logic            tx_valid_q;
  logic            wr_en;
  logic            is_cr, is_bs, hs, last_char;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign is_cr     = (rx_data == DATA_WIDTH'(CHAR_CR));
  assign is_bs     = (rx_data == DATA_WIDTH'(CHAR_BS));
  assign hs        = tx_valid_q && tx_ready;
  assign last_char = ((LW'(rd_idx_q) + LW'(1)) == len_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_idx_d = rd_idx_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    case (state_q)
      COLLECT: begin
        rd_idx_d = '0;
        if (rx_valid) begin
          if (is_cr) begin
            state_d = (len_q != '0) ? DRAIN : SEND_CR;
          end else if (is_bs) begin
            if (len_q != '0) len_d = len_q - LW'(1);
          end else if (len_q == LW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            len_d = len_q + LW'(1);
          end
        end
      end
      DRAIN: begin
        if (hs) begin
          if (last_char) begin
            state_d  = SEND_CR;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
          end
        end
      end
      SEND_CR: begin
        if (hs) state_d = SEND_LF;
      end
      SEND_LF: begin
        if (hs) begin
          state_d = COLLECT;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= COLLECT;
      len_q      <= '0;
      rd_idx_q   <= '0;
      ovf_q      <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      ovf_q      <= ovf_d;
      tx_valid_q <= (state_d != COLLECT);
    end
  end

  // Read address follows the next index so the registered read lands with the state.
  line_buf_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(len_q[AW-1:0]),
    .wdata_i(rx_data),
    .raddr_i(rd_idx_d),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    tx_data = '0;
    case (state_q)
      DRAIN:   tx_data = ram_rdata;
      SEND_CR: tx_data = DATA_WIDTH'(CHAR_CR);
      SEND_LF: tx_data = DATA_WIDTH'(CHAR_LF);
      default: tx_data = '0;
    endcase
  end

  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != COLLECT);
  assign line_len = len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: directed scenarios plus random lines against a queue-based line model.
module tb_uart_line_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [LW-1:0] line_len;
  logic          busy;
  logic          overflow;

  uart_line_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .line_len(line_len),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stored line, expected tx bytes, outstanding transfers.
  logic [7:0] mq[$];
  logic [7:0] eq[$];
  int         pend = 0;
  bit         movf = 1'b0;
  bit         armed = 1'b0;

  always @(negedge clk) begin
    bit busy_now;
    if (armed) begin
      chk("busy", busy, pend > 0);
      chk("tx_valid", tx_valid, pend > 0);
      chk("line_len", line_len, mq.size());
      chk("overflow", overflow, movf);
      if (tx_valid && eq.size() > 0) chk("tx_data", tx_data, eq[0]);
    end
    if (!rstn) begin
      mq.delete();
      eq.delete();
      pend  = 0;
      movf  = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      busy_now = (pend > 0);
      if (busy_now && tx_valid && tx_ready) begin
        void'(eq.pop_front());
        pend--;
        if (pend == 0) begin
          mq.delete();
          movf = 1'b0;
        end
      end
      if (!busy_now && rx_valid) begin
        if (rx_data == 8'h0D) begin
          eq = mq;
          eq.push_back(8'h0D);
          eq.push_back(8'h0A);
          pend = mq.size() + 2;
        end else if (rx_data == 8'h08) begin
          if (mq.size() > 0) void'(mq.pop_back());
        end else if (mq.size() == DEPTH) begin
          movf = 1'b1;
        end else begin
          mq.push_back(rx_data);
        end
      end
    end
  end

  bit rdy_mode = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] c);
    rx_valid = 1'b1;
    rx_data  = c;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (pend > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", pend, 0);
  endtask

  initial begin
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_line_len", line_len, 0);
    rstn     = 1'b1;
    tx_ready = 1'b1;
    tick();

    // "abc" CR
    send_str("abc");
    send(8'h0D);
    chk("abc_busy", busy, 1);
    wait_idle(100);
    tick();
    chk("abc_len_after", line_len, 0);

    // backspace on empty line, then edited line
    send(8'h08);
    tick();
    chk("bs_empty_len", line_len, 0);
    send_str("ab");
    send(8'h08);
    send_str("c");
    chk("bs_len", line_len, 2);
    send(8'h0D);
    wait_idle(100);

    // empty line
    send(8'h0D);
    chk("empty_tx_data", tx_data, 8'h0D);
    wait_idle(100);

    // overflow
    repeat (32) send(8'h78);
    chk("ovf_32", overflow, 0);
    send(8'h78);
    chk("ovf_33", overflow, 1);
    send(8'h78);
    send(8'h0D);
    wait_idle(200);
    tick();
    chk("ovf_clear", overflow, 0);

    // stall during drain, rx discarded
    send_str("hi");
    tx_ready = 1'b0;
    send(8'h0D);
    for (int i = 0; i < 50; i++) begin
      if (i == 25) send(8'h7A);
      else tick();
    end
    chk("stall_data", tx_data, 8'h68);
    chk("stall_valid", tx_valid, 1);
    chk("stall_len", line_len, 2);
    tx_ready = 1'b1;
    wait_idle(100);

    // reset during SEND_CR
    tx_ready = 1'b0;
    send(8'h61);
    send(8'h0D);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("pre_rst_cr", tx_data, 8'h0D);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("post_rst_valid", tx_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_len", line_len, 0);
    tx_ready = 1'b1;
    send(8'h71);
    send(8'h0D);
    wait_idle(100);

    // random lines with random backpressure and junk rx while busy
    rdy_mode = 1'b1;
    for (int ln = 0; ln < 30; ln++) begin
      int len;
      len = $urandom_range(0, 40);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) send(8'h08);
        else send(8'($urandom_range(8'h20, 8'h7E)));
        if ($urandom_range(0, 3) == 0) tick();
      end
      send(8'h0D);
      for (int n = 0; n < 400 && pend > 0; n++) begin
        if ($urandom_range(0, 3) == 0) send(8'($urandom_range(8'h20, 8'h7E)));
        else tick();
      end
      wait_idle(500);
    end
    rdy_mode = 1'b0;
    tx_ready = 1'b1;

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_line_buffer.md
UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, character width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, maximum stored characters per line (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_data  input  DATA_WIDTH  received character from uart_rx.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data; no backpressure.
REQ-007 SHALL have port tx_data  output  DATA_WIDTH  character to uart_tx.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid; held until accepted.
REQ-009 SHALL have port tx_ready  input  1  uart_tx can accept; transfer when tx_valid && tx_ready.
REQ-010 SHALL have port line_len  output  $clog2(DEPTH+1)  characters currently stored.
REQ-011 SHALL have port busy  output  1  high while a line is being transmitted.
REQ-012 SHALL have port overflow  output  1  sticky: a character was dropped in the current line.

Function
REQ-013 SHALL implement states COLLECT, DRAIN, SEND_CR, SEND_LF.
REQ-014 In COLLECT, an rx_valid printable character (not 0x0D, not 0x08) SHALL be written at index line_len and line_len incremented the next cycle.
REQ-015 In COLLECT, rx_valid with 0x08 SHALL decrement line_len; at line_len==0 it SHALL be ignored.
REQ-016 In COLLECT, rx_valid with line_len==DEPTH and a non-control character SHALL drop the character and set overflow; no automatic flush.
REQ-017 In COLLECT, rx_valid with 0x0D SHALL move to DRAIN if line_len>0, else directly to SEND_CR.
REQ-018 tx_valid SHALL rise the cycle after the state transition (registered output), tx_data = stored[0] in DRAIN.
REQ-019 In DRAIN, each handshake SHALL advance the read index; the next character SHALL be presented the following cycle with tx_valid kept high; after index line_len-1 is accepted, move to SEND_CR.
REQ-020 SEND_CR SHALL present 0x0D, then SEND_LF SHALL present 0x0A; after the LF handshake return to COLLECT with line_len=0, overflow=0, tx_valid=0.
REQ-021 tx_data SHALL be stable and tx_valid SHALL not drop while tx_valid && !tx_ready.
REQ-022 rx_valid outside COLLECT SHALL be discarded and SHALL NOT set overflow.
REQ-023 busy SHALL be high in DRAIN, SEND_CR, SEND_LF, low in COLLECT.
REQ-024 line_len SHALL hold its value during DRAIN/SEND_CR/SEND_LF; index arithmetic SHALL never wrap past DEPTH.

Reset
REQ-025 With rstn low at a clock edge: state=COLLECT, line_len=0, read index=0, tx_valid=0, tx_data=0, busy=0, overflow=0.
REQ-026 Reset mid-transmission SHALL abandon the line immediately; buffer contents need not be cleared.

Structure
REQ-027 Package uart_pkg SHALL hold the state typedef and constants CHAR_CR=0x0D, CHAR_LF=0x0A, CHAR_BS=0x08.
REQ-028 Storage SHALL be a sub-module line_buf_ram (one write port, one registered read port, DEPTH x DATA_WIDTH, no reset).

Verification
REQ-029 Send "abc",0x0D via rx_valid strobes, tx_ready=1 -> tx bytes 0x61,0x62,0x63,0x0D,0x0A; busy high throughout; line_len=0 after.
REQ-030 Send "ab",0x08,"c",0x0D -> tx 0x61,0x63,0x0D,0x0A; 0x08 at line_len=0 -> line_len stays 0.
REQ-031 Send 0x0D on empty line -> tx exactly 0x0D,0x0A; busy high 2 handshakes.
REQ-032 Send 34 'x' then 0x0D, DEPTH=32 -> overflow=1 after 33rd char, 32 'x' + CR LF transmitted, overflow=0 after LF.
REQ-033 Hold tx_ready low 50 cycles during DRAIN of "hi" -> tx_data=0x68 stable, tx_valid high; rx_valid 'z' meanwhile discarded, no output.
REQ-034 Assert rstn low during SEND_CR -> next cycle tx_valid=0, busy=0, line_len=0; subsequent "q",0x0D transmits 0x71,0x0D,0x0A.
